// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue.
package fetch_queue_pkg;

  localparam int unsigned FETCH_WIDTH = 64;

  // Canonical NOP (addi x0, x0, 0) shown to decode whenever no real word is offered.
  localparam logic [63:0] STALL = 64'h0000_0000_0000_0013;

  typedef logic [0:FETCH_WIDTH-1] instr_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for fetch_queue: one write port, one asynchronous read port, no reset.
module fetch_queue_ram #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// DEPTH-entry instruction FIFO between fetch and decode with halt and flush.
// Optional 0-cycle empty-queue bypass enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned WIDTH = FETCH_WIDTH,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] STALL_W = WIDTH'(STALL);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_nonempty;
  logic             w_head_valid;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head_data;

  assign w_nonempty   = (r_count != '0);
  assign w_head_valid = w_nonempty & ~halt & ~flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = ~w_nonempty & ~halt & ~flush & in_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign in_ready  = (r_count < DEPTH_C);
  assign out_valid = w_head_valid | w_bypass;

  always_comb begin
    out_instr = STALL_W;
    if (w_head_valid) begin
      out_instr = w_head_data;
    end else if (w_bypass) begin
      out_instr = in_instr;
    end
  end

  // A bypassed word consumed in the same cycle never touches storage.
  assign w_push = in_valid & in_ready & ~flush & ~(w_bypass & out_ready);
  assign w_pop  = w_head_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign count = r_count;

  fetch_queue_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_tail),
    .i_wdata (in_instr),
    .i_raddr (r_head),
    .o_rdata (w_head_data)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, WIDTH=64).
module tb_fetch_queue;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [63:0] STALL_EXP = 64'h13;

  logic             clk;
  logic             rst;
  logic             halt;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_instr;
  logic [CNT_W-1:0] count;

  int n_total;
  int n_bad;

  fetch_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .halt      (halt),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] base, input int n);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_instr = base + 64'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b0;
    halt      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;
    #12 rst = 1'b1;
    tick();

    // Reset / idle
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_instr", out_instr, STALL_EXP);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);

    // Fill, overflow attempt, drain
    load(64'hA1, 4);
    check("full_count", 64'(count), 64'd4);
    check("full_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_instr = 64'hA5;
    tick();
    in_valid = 1'b0;
    check("ovf_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_valid", 64'(out_valid), 64'd1);
      check("drain_instr", out_instr, 64'hA1 + 64'(i));
      tick();
    end
    check("drain_count", 64'(count), 64'd0);
    check("drain_instr_empty", out_instr, STALL_EXP);

    // Streaming with pointer wrap
    for (int k = 0; k < 10; k++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_instr  = 64'h10 + 64'(k);
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      check("stream_instr", out_instr, 64'h10 + 64'(k));
      check("stream_count", 64'(count), 64'd0);
`else
      if (k > 0) begin
        check("stream_instr", out_instr, 64'h0F + 64'(k));
      end
      check("stream_count", 64'(count), (k == 0) ? 64'd0 : 64'd1);
`endif
      tick();
    end
    in_valid = 1'b0;
`ifndef FETCH_QUEUE_BYPASS_EN
    #1;
    check("stream_last", out_instr, 64'h19);
    tick();
`endif
    check("stream_end_count", 64'(count), 64'd0);

    // Halt while pushing
    load(64'h31, 3);
    halt      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 64'hB0;
    #1;
    check("halt_valid", 64'(out_valid), 64'd0);
    check("halt_instr", out_instr, STALL_EXP);
    tick();
    in_valid = 1'b0;
    check("halt_count1", 64'(count), 64'd4);
    check("halt_instr2", out_instr, STALL_EXP);
    tick();
    check("halt_count2", 64'(count), 64'd4);
    halt = 1'b0;
    #1;
    check("unhalt_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("unhalt_instr", out_instr, (i == 3) ? 64'hB0 : 64'h31 + 64'(i));
      tick();
    end
    check("unhalt_count", 64'(count), 64'd0);

    // Flush with a same-cycle push
    load(64'h41, 2);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 64'hC0;
    #1;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_instr", out_instr, STALL_EXP);
    check("flush_ready", 64'(in_ready), 64'd1);
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("flush_count", 64'(count), 64'd0);
    check("flush_after_instr", out_instr, STALL_EXP);
    tick();
    check("flush_after_valid", 64'(out_valid), 64'd0);

    // Empty-queue latency (bypass or one cycle)
    in_valid  = 1'b1;
    in_instr  = 64'hD0;
    out_ready = 1'b1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("byp_valid", 64'(out_valid), 64'd1);
    check("byp_instr", out_instr, 64'hD0);
    tick();
    in_valid = 1'b0;
    check("byp_count", 64'(count), 64'd0);
`else
    check("lat_valid0", 64'(out_valid), 64'd0);
    check("lat_instr0", out_instr, STALL_EXP);
    tick();
    in_valid = 1'b0;
    check("lat_instr1", out_instr, 64'hD0);
    check("lat_count1", 64'(count), 64'd1);
    tick();
    check("lat_count2", 64'(count), 64'd0);
`endif

    // Asynchronous reset mid-operation
    load(64'h51, 2);
    check("prerst_count", 64'(count), 64'd2);
    rst = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_instr", out_instr, STALL_EXP);
    rst = 1'b1;
    tick();
    check("arst_ready", 64'(in_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
